policy_client: RTL and testbench
================================

Name: policy_client

Overview:
- Requester-side endpoint of the policy-check link. Sits inside the IP firewall / hardware sandbox wrapper, between the bus-transaction checker and the policy server.
- Takes an access request (process id, IP id, read/write) and drives it onto the link as WSO/UpdateWR. Waits for CaptureWR, captures the permission word on WSI and returns grant/deny.
- Runs a no-response timeout and keeps saturating statistics.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles spent in REQ or WAIT_REL before abort; legal range 2..65535.
- CNT_W, 16, width of grant_count and deny_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- req_valid  in  1  request strobe from transaction checker
- req_ready  out  1  client can accept request
- req_pid  in  16  process id
- req_ipid  in  14  IP id
- req_write  in  1  1=write access, 0=read access
- resp_valid  out  1  one-cycle result strobe
- resp_grant  out  1  access permitted (valid with resp_valid)
- resp_timeout  out  1  result produced by timeout (valid with resp_valid)
- WSO  out  32  request word to server: {pid[15:0], ipid[13:0], 2'b00}
- UpdateWR  out  1  go / request-active to server
- WSI  in  32  permission word from server
- CaptureWR  in  1  server ready / response valid
- clr_stats  in  1  clear counters and link_err
- grant_count  out  CNT_W  saturating grant count
- deny_count  out  CNT_W  saturating deny count (includes timeouts)
- link_err  out  1  sticky; CaptureWR stuck high past timeout

Behaviour:
- Reset: state IDLE. WSO=0, UpdateWR=0, resp_valid=0, resp_grant=0, resp_timeout=0, counters=0, link_err=0, timer=0.
- req_ready = (state==IDLE) && !CaptureWR. This is combinational from state and CaptureWR.
- IDLE:
  - On req_valid && req_ready at edge T: latch pid, ipid and write, then go to REQ.
  - WSO = {pid,ipid,2'b00} and UpdateWR=1 from T+1.
  - Timer cleared.
- REQ:
  - WSO and UpdateWR held stable; timer increments each cycle.
  - CaptureWR=1 sampled at edge C: latch WSI, drop UpdateWR, go to WAIT_REL. resp_valid=1 during cycle C+1 only.
  - grant = (WSI[31:2] == latched WSO[31:2]) && (write ? WSI[1] : WSI[0]). An all-zero WSI is therefore always a deny.
  - Timer reaches TIMEOUT_CYCLES-1 with no CaptureWR: drop UpdateWR, resp_valid=1 with resp_grant=0 and resp_timeout=1, go to WAIT_REL.
  - CaptureWR on the same edge as timer expiry: capture wins (normal result).
- WAIT_REL:
  - Timer is restarted on entry. Return to IDLE on the first cycle CaptureWR==0.
  - If CaptureWR stays high for TIMEOUT_CYCLES cycles: set link_err and return to IDLE anyway. req_ready stays low until CaptureWR drops.
- WSO returns to 0 on leaving REQ.
- Only one outstanding request. req_valid while busy is ignored, with no queuing.
- CaptureWR seen in IDLE is ignored; it only blocks req_ready.
- Counters:
  - grant_count++ on resp_valid&&resp_grant; deny_count++ on resp_valid&&!resp_grant.
  - Both saturate at all-ones.
  - clr_stats zeroes both counters and link_err, and beats a same-cycle increment.
- Reset mid-operation: UpdateWR and WSO go to 0 at that edge. No resp_valid is produced for the aborted request.

Test Plan:
- Read grant: req pid=0x0003, ipid=0x0001, write=0. Server returns CaptureWR with WSI=0x00030005 two cycles after UpdateWR. Expect WSO=0x00030004 held until capture, UpdateWR drops, one resp_valid with grant=1, timeout=0, grant_count=1.
- Write deny on permission: same request with write=1 and WSI=0x00030005 (bit1=0) -> resp_grant=0, deny_count=1. Write=1 with WSI=0x00030006 -> grant.
- Id mismatch: WSI=0x00040005 for pid=3 -> deny. WSI=0 (server busy writing) -> deny.
- Timeout: TIMEOUT_CYCLES=8, server never answers -> UpdateWR high exactly 8 cycles, then resp_valid with grant=0, timeout=1. req_ready high one cycle later.
- Stuck ready: CaptureWR held high after response for 8 cycles -> link_err=1, IDLE reached, req_ready low until CaptureWR falls. clr_stats clears link_err and counters.
- Saturation and reset: with CNT_W=4, 17 grants -> grant_count=15. rst asserted while in REQ -> UpdateWR=0 next cycle, no resp_valid.

Source files
------------

// File: rtl/policy_client_if.sv
// Policy-check link bundle: request/response side toward the transaction
// checker plus the WSO/WSI word link toward the policy server.
interface policy_client_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_pid;
  logic [13:0] req_ipid;
  logic        req_write;
  logic        resp_valid;
  logic        resp_grant;
  logic        resp_timeout;
  logic [31:0] WSO;
  logic        UpdateWR;
  logic [31:0] WSI;
  logic        CaptureWR;

  // master is the policy client, slave is the checker/server environment
  modport master (
    input  req_valid, req_pid, req_ipid, req_write, WSI, CaptureWR,
    output req_ready, resp_valid, resp_grant, resp_timeout, WSO, UpdateWR
  );

  modport slave (
    output req_valid, req_pid, req_ipid, req_write, WSI, CaptureWR,
    input  req_ready, resp_valid, resp_grant, resp_timeout, WSO, UpdateWR
  );
endinterface

// File: rtl/policy_client.sv
// Requester endpoint of the policy-check link: issues one access request,
// captures the permission word or times out, and keeps saturating statistics.
module policy_client #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  policy_client_if.master  link,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] grant_count,
  output logic [CNT_W-1:0] deny_count,
  output logic             link_err
);

  localparam int unsigned      TMR_W    = 16;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_REL
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [31:0]      wso_q, wso_d;
  logic             upd_q, upd_d;
  logic             write_q, write_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_grant_q, resp_grant_d;
  logic             resp_timeout_q, resp_timeout_d;
  logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [CNT_W-1:0] deny_cnt_q, deny_cnt_d;
  logic             link_err_q, link_err_d;
  logic             req_ready_c;
  logic             cap_grant_c;

  assign req_ready_c = (state_q == IDLE) && !link.CaptureWR;

  // Server must echo our pid/ipid and set the permission bit for the access kind
  assign cap_grant_c = (link.WSI[31:2] == wso_q[31:2]) &&
                       (write_q ? link.WSI[1] : link.WSI[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      wso_q          <= '0;
      upd_q          <= 1'b0;
      write_q        <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_grant_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      grant_cnt_q    <= '0;
      deny_cnt_q     <= '0;
      link_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      wso_q          <= wso_d;
      upd_q          <= upd_d;
      write_q        <= write_d;
      resp_valid_q   <= resp_valid_d;
      resp_grant_q   <= resp_grant_d;
      resp_timeout_q <= resp_timeout_d;
      grant_cnt_q    <= grant_cnt_d;
      deny_cnt_q     <= deny_cnt_d;
      link_err_q     <= link_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    wso_d          = wso_q;
    upd_d          = upd_q;
    write_d        = write_q;
    resp_valid_d   = 1'b0;
    resp_grant_d   = 1'b0;
    resp_timeout_d = 1'b0;
    link_err_d     = link_err_q;
    grant_cnt_d    = grant_cnt_q;
    deny_cnt_d     = deny_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (link.req_valid && req_ready_c) begin
          state_d = REQ;
          wso_d   = {link.req_pid, link.req_ipid, 2'b00};
          upd_d   = 1'b1;
          write_d = link.req_write;
          timer_d = '0;
        end
      end
      REQ: begin
        // A capture on the expiry edge still yields a normal result
        if (link.CaptureWR) begin
          state_d      = WAIT_REL;
          upd_d        = 1'b0;
          wso_d        = '0;
          timer_d      = '0;
          resp_valid_d = 1'b1;
          resp_grant_d = cap_grant_c;
        end else if (timer_q == TMR_LAST) begin
          state_d        = WAIT_REL;
          upd_d          = 1'b0;
          wso_d          = '0;
          timer_d        = '0;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_REL: begin
        if (!link.CaptureWR) begin
          state_d = IDLE;
        end else if (timer_q == TMR_LAST) begin
          state_d    = IDLE;
          link_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (resp_valid_q && resp_grant_q && (grant_cnt_q != CNT_MAX)) begin
      grant_cnt_d = grant_cnt_q + CNT_W'(1);
    end
    if (resp_valid_q && !resp_grant_q && (deny_cnt_q != CNT_MAX)) begin
      deny_cnt_d = deny_cnt_q + CNT_W'(1);
    end

    if (clr_stats) begin
      grant_cnt_d = '0;
      deny_cnt_d  = '0;
      link_err_d  = 1'b0;
    end
  end

  assign link.req_ready    = req_ready_c;
  assign link.WSO          = wso_q;
  assign link.UpdateWR     = upd_q;
  assign link.resp_valid   = resp_valid_q;
  assign link.resp_grant   = resp_grant_q;
  assign link.resp_timeout = resp_timeout_q;
  assign grant_count       = grant_cnt_q;
  assign deny_count        = deny_cnt_q;
  assign link_err          = link_err_q;

endmodule

// File: tb/tb_policy_client.sv
// Self-checking bench for policy_client: directed scenarios plus randomized
// transactions compared against a transaction-level permission model.
module tb_policy_client;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic clr_stats;
  logic [CNT_W-1:0] grant_count;
  logic [CNT_W-1:0] deny_count;
  logic link_err;

  int n_checks = 0;
  int n_pass   = 0;
  int m_grant  = 0;
  int m_deny   = 0;

  policy_client_if link();

  policy_client #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .link       (link),
    .clr_stats  (clr_stats),
    .grant_count(grant_count),
    .deny_count (deny_count),
    .link_err   (link_err)
  );

  always #5 clk = ~clk;

  // One full transaction; the server answers after `delay` extra UpdateWR cycles
  task automatic run_txn(input string tag, input logic [15:0] pid, input logic [13:0] ipid,
                         input logic wr, input int delay, input logic [31:0] wsi);
    logic [31:0] exp_wso;
    bit exp_to, exp_gr, g, t;
    int upd, resp_n, bad_wso, resp_at, ready_at, exp_upd;
    exp_wso = {pid, ipid, 2'b00};
    exp_to  = (delay >= TIMEOUT);
    exp_gr  = !exp_to && (wsi[31:16] == pid) && (wsi[15:2] == ipid) && (wr ? wsi[1] : wsi[0]);
    exp_upd = exp_to ? TIMEOUT : delay + 1;
    upd = 0; resp_n = 0; bad_wso = 0; resp_at = -1; ready_at = -1; g = 0; t = 0;

    n_checks++;
    if (link.req_ready !== 1'b1) $display("FAIL %s ready_before: got %b want 1", tag, link.req_ready);
    else n_pass++;

    link.req_valid = 1'b1; link.req_pid = pid; link.req_ipid = ipid; link.req_write = wr;
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      @(negedge clk);
      link.req_valid = 1'b0;
      link.CaptureWR = 1'b0;
      link.WSI       = '0;
      if (link.UpdateWR) begin
        upd++;
        if (link.WSO !== exp_wso) bad_wso++;
      end
      if (link.resp_valid) begin
        resp_n++; resp_at = i; g = link.resp_grant; t = link.resp_timeout;
      end
      if (resp_at >= 0 && ready_at < 0 && link.req_ready) ready_at = i;
      if (link.UpdateWR && upd == delay + 1) begin
        link.CaptureWR = 1'b1;
        link.WSI       = wsi;
      end
    end

    if (exp_gr) m_grant = (m_grant == CNT_MAX) ? CNT_MAX : m_grant + 1;
    else        m_deny  = (m_deny  == CNT_MAX) ? CNT_MAX : m_deny + 1;

    n_checks++;
    if (upd != exp_upd) $display("FAIL %s upd_cycles: got %0d want %0d", tag, upd, exp_upd);
    else n_pass++;
    n_checks++;
    if (bad_wso != 0) $display("FAIL %s wso_value: got %0d bad cycles want 0 (want %h)", tag, bad_wso, exp_wso);
    else n_pass++;
    n_checks++;
    if (resp_n != 1) $display("FAIL %s resp_count: got %0d want 1", tag, resp_n);
    else n_pass++;
    n_checks++;
    if (g !== exp_gr) $display("FAIL %s resp_grant: got %b want %b", tag, g, exp_gr);
    else n_pass++;
    n_checks++;
    if (t !== exp_to) $display("FAIL %s resp_timeout: got %b want %b", tag, t, exp_to);
    else n_pass++;
    n_checks++;
    if (ready_at != resp_at + 1) $display("FAIL %s ready_gap: got %0d want %0d", tag, ready_at - resp_at, 1);
    else n_pass++;
    n_checks++;
    if (grant_count !== CNT_W'(m_grant) || deny_count !== CNT_W'(m_deny))
      $display("FAIL %s counters: got g=%0d d=%0d want g=%0d d=%0d", tag, grant_count, deny_count, m_grant, m_deny);
    else n_pass++;
  endtask

  task automatic do_clr();
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    m_grant = 0; m_deny = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_stats = 1'b0;
    link.req_valid = 1'b0; link.req_pid = '0; link.req_ipid = '0; link.req_write = 1'b0;
    link.WSI = '0; link.CaptureWR = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (link.UpdateWR !== 1'b0 || link.WSO !== 32'h0) $display("FAIL reset_link: got upd=%b wso=%h want 0", link.UpdateWR, link.WSO);
    else n_pass++;
    n_checks++;
    if (link.resp_valid !== 1'b0 || link.resp_grant !== 1'b0 || link.resp_timeout !== 1'b0)
      $display("FAIL reset_resp: got %b%b%b want 000", link.resp_valid, link.resp_grant, link.resp_timeout);
    else n_pass++;
    n_checks++;
    if (grant_count !== '0 || deny_count !== '0 || link_err !== 1'b0)
      $display("FAIL reset_stats: got g=%0d d=%0d err=%b want 0", grant_count, deny_count, link_err);
    else n_pass++;
    n_checks++;
    if (link.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", link.req_ready);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_grant();
    run_txn("read_grant", 16'h0003, 14'h0001, 1'b0, 2, 32'h0003_0005);
  endtask

  task automatic test_permissions();
    run_txn("write_deny", 16'h0003, 14'h0001, 1'b1, 2, 32'h0003_0005);
    run_txn("write_grant", 16'h0003, 14'h0001, 1'b1, 1, 32'h0003_0006);
    run_txn("read_deny", 16'h0003, 14'h0001, 1'b0, 0, 32'h0003_0006);
  endtask

  task automatic test_mismatch();
    run_txn("pid_mismatch", 16'h0003, 14'h0001, 1'b0, 2, 32'h0004_0005);
    run_txn("ipid_mismatch", 16'h0003, 14'h0001, 1'b0, 3, 32'h0003_0009);
    run_txn("wsi_zero", 16'h0000, 14'h0000, 1'b0, 2, 32'h0000_0000);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 16'h1234, 14'h0abc, 1'b0, TIMEOUT + 3, {16'h1234, 14'h0abc, 2'b11});
    run_txn("capture_at_expiry", 16'h1234, 14'h0abc, 1'b1, TIMEOUT - 1, {16'h1234, 14'h0abc, 2'b10});
  endtask

  task automatic test_stuck();
    int k;
    link.req_valid = 1'b1; link.req_pid = 16'h0003; link.req_ipid = 14'h0001; link.req_write = 1'b0;
    @(negedge clk);
    link.req_valid = 1'b0; link.CaptureWR = 1'b1; link.WSI = 32'h0003_0005;
    @(negedge clk);
    n_checks++;
    if (link.resp_valid !== 1'b1 || link.resp_grant !== 1'b1)
      $display("FAIL stuck_resp: got v=%b g=%b want 1 1", link.resp_valid, link.resp_grant);
    else n_pass++;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0; m_grant = 0; m_deny = 0;
    n_checks++;
    if (grant_count !== '0 || deny_count !== '0) $display("FAIL clr_beats_inc: got g=%0d d=%0d want 0", grant_count, deny_count);
    else n_pass++;
    k = 1;
    while (link_err !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (link_err !== 1'b1 || k != TIMEOUT) $display("FAIL stuck_link_err: got err=%b after %0d want 1 after %0d", link_err, k, TIMEOUT);
    else n_pass++;
    n_checks++;
    if (link.req_ready !== 1'b0) $display("FAIL stuck_ready_low: got %b want 0", link.req_ready);
    else n_pass++;
    link.req_valid = 1'b1;
    @(negedge clk);
    link.req_valid = 1'b0;
    n_checks++;
    if (link.UpdateWR !== 1'b0 || link.req_ready !== 1'b0 || link_err !== 1'b1)
      $display("FAIL stuck_ignore_req: got upd=%b rdy=%b err=%b want 0 0 1", link.UpdateWR, link.req_ready, link_err);
    else n_pass++;
    link.CaptureWR = 1'b0; link.WSI = '0;
    #1;
    n_checks++;
    if (link.req_ready !== 1'b1) $display("FAIL stuck_ready_release: got %b want 1", link.req_ready);
    else n_pass++;
    @(negedge clk);
    do_clr();
    n_checks++;
    if (link_err !== 1'b0) $display("FAIL clr_link_err: got %b want 0", link_err);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] pid;
    logic [13:0] ipid;
    logic [31:0] wsi;
    int mode, delay;
    for (int n = 0; n < 40; n++) begin
      pid   = 16'($urandom);
      ipid  = 14'($urandom);
      mode  = int'($urandom_range(0, 3));
      delay = int'($urandom_range(0, TIMEOUT + 2));
      case (mode)
        0, 1:    wsi = {pid, ipid, 2'($urandom)};
        2:       wsi = $urandom;
        default: wsi = '0;
      endcase
      run_txn("random", pid, ipid, 1'($urandom), delay, wsi);
    end
  endtask

  task automatic test_saturation();
    do_clr();
    for (int n = 0; n < 17; n++) begin
      run_txn("sat_grant", 16'h00a5, 14'h0015, 1'b0, 0, {16'h00a5, 14'h0015, 2'b01});
    end
    n_checks++;
    if (grant_count !== 4'hF) $display("FAIL grant_saturate: got %0d want 15", grant_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    link.req_valid = 1'b1; link.req_pid = 16'h0042; link.req_ipid = 14'h0007; link.req_write = 1'b1;
    @(negedge clk);
    link.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (link.UpdateWR !== 1'b1) $display("FAIL midrst_in_req: got upd=%b want 1", link.UpdateWR);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (link.UpdateWR !== 1'b0 || link.WSO !== 32'h0 || link.resp_valid !== 1'b0)
      $display("FAIL midrst_abort: got upd=%b wso=%h v=%b want 0 0 0", link.UpdateWR, link.WSO, link.resp_valid);
    else n_pass++;
    rst = 1'b0; m_grant = 0; m_deny = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (link.resp_valid || link.UpdateWR) bad++;
    end
    n_checks++;
    if (bad != 0 || link.req_ready !== 1'b1 || grant_count !== '0 || deny_count !== '0)
      $display("FAIL midrst_quiet: got %0d active cycles rdy=%b g=%0d d=%0d want 0 1 0 0",
               bad, link.req_ready, grant_count, deny_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_grant();
    test_permissions();
    test_mismatch();
    test_timeout();
    test_stuck();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
